// File: rtl/trdb_d5m_sensor_emulator_pkg.sv
// Shared types for the TRDB-D5M sensor emulator.
// States, pattern codes, pixel width and counter sizing.
package tPTRDB_D5M_Emu;

  localparam int PIX_W = 12;

  typedef enum logic [2:0] {
    IDLE,
    P1,
    LINE,
    HBLANK,
    P2,
    VBLANK
  } stateT;

  typedef enum logic [1:0] {
    COL_RAMP,
    ROW_RAMP,
    CHECKER,
    FRAME_TAG
  } patternT;

  function automatic int cntW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int maxW(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trdb_d5m_sensor_emulator_patgen.sv
// Combinational test-pattern select for the sensor emulator.
// Output is registered by the top-level FSM stage.
module tMD5MPatternGen
  import tPTRDB_D5M_Emu::*;
(
  input  logic [PIX_W-1:0] col,
  input  logic [PIX_W-1:0] row,
  input  logic [3:0]       frame,
  input  patternT          pattern,
  output logic [PIX_W-1:0] pixel
);

  always_comb begin
    pixel = '0;
    unique case (pattern)
      COL_RAMP:  pixel = col;
      ROW_RAMP:  pixel = row;
      CHECKER:   pixel = (col[3] ^ row[3]) ? 12'hFFF : 12'h000;
      FRAME_TAG: pixel = {frame, col[7:0]};
      default:   pixel = '0;
    endcase
  end

endmodule

// File: rtl/trdb_d5m_sensor_emulator.sv
// TRDB-D5M sensor emulator: FVAL/LVAL/Bayer pixel stream generator.
// Config: TRDB_D5M_EMU_SNAPSHOT_EN enables snapshot (triggered) frames.
module trdb_d5m_sensor_emulator
  import tPTRDB_D5M_Emu::*;
#(
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int HBLANK_CC   = 16,
  parameter int P1_CC       = 8,
  parameter int P2_CC       = 8,
  parameter int VBLANK_CC   = 64
) (
  input  logic             piul1Clock,
  input  logic             piul1Reset_n,
  input  logic             piul1Enable,
  input  logic [1:0]       piul2Pattern,
  input  logic             piul1SnapshotMode,
  input  logic             piul1SnapshotTrigger,
  output logic             poul1FrameValid,
  output logic             poul1LineValid,
  output logic [PIX_W-1:0] poul12PixelData,
  output logic             poul1SnapshotStrobe,
  output logic [15:0]      poul16FrameCount
);

  localparam int CW  = cntW(ACTIVE_COLS);
  localparam int RW  = cntW(ACTIVE_ROWS);
  localparam int PWa = maxW(cntW(P1_CC), cntW(P2_CC));
  localparam int PWb = maxW(cntW(HBLANK_CC), cntW(VBLANK_CC));
  localparam int PW  = maxW(PWa, PWb);

  stateT           state;
  stateT           nxt;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic [PW-1:0]   phase;
  patternT         patLat;
  logic            snapFrame;
  logic            start;
  logic            modeIn;
  logic            lastPh;
  logic            entryP1;
  logic [PIX_W-1:0] pix;
  logic            fvalD;
  logic            lvalD;
  logic            strobeD;
  logic [PIX_W-1:0] dataD;

  assign entryP1 = (nxt == P1) && (state != P1);

`ifdef TRDB_D5M_EMU_SNAPSHOT_EN
  logic trigQ;
  logic pending;

  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      trigQ   <= 1'b0;
      pending <= 1'b0;
    end else begin
      trigQ <= piul1SnapshotTrigger;
      if (entryP1)
        pending <= 1'b0;
      else if (piul1SnapshotTrigger && !trigQ)
        pending <= 1'b1;
    end
  end

  assign start  = piul1Enable && (!piul1SnapshotMode || pending);
  assign modeIn = piul1SnapshotMode;
`else
  logic unusedSnap;
  assign unusedSnap = piul1SnapshotMode ^ piul1SnapshotTrigger;
  assign start      = piul1Enable;
  assign modeIn     = 1'b0;
`endif

  always_comb begin
    lastPh = 1'b0;
    unique case (state)
      P1:      lastPh = (phase == PW'(P1_CC - 1));
      HBLANK:  lastPh = (phase == PW'(HBLANK_CC - 1));
      P2:      lastPh = (phase == PW'(P2_CC - 1));
      VBLANK:  lastPh = (phase == PW'(VBLANK_CC - 1));
      default: lastPh = 1'b0;
    endcase
  end

  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) state <= IDLE;
    else               state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (start) nxt = P1;
      P1:     if (lastPh) nxt = LINE;
      LINE:
        if (col == CW'(ACTIVE_COLS - 1))
          nxt = (row == RW'(ACTIVE_ROWS - 1)) ? P2 : HBLANK;
      HBLANK: if (lastPh) nxt = LINE;
      P2:     if (lastPh) nxt = VBLANK;
      VBLANK: if (lastPh) nxt = start ? P1 : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      phase     <= '0;
      col       <= '0;
      row       <= '0;
      patLat    <= COL_RAMP;
      snapFrame <= 1'b0;
    end else begin
      if (nxt != state)
        phase <= '0;
      else if (state != IDLE && state != LINE)
        phase <= phase + 1'b1;
      if (state == LINE)
        col <= (col == CW'(ACTIVE_COLS - 1)) ? '0 : col + 1'b1;
      if (state == P1)
        row <= '0;
      else if (state == HBLANK && nxt == LINE)
        row <= row + 1'b1;
      if (entryP1) begin
        patLat    <= patternT'(piul2Pattern);
        snapFrame <= modeIn;
      end
    end
  end

  tMD5MPatternGen uPatGen (
    .col     (PIX_W'(col)),
    .row     (PIX_W'(row)),
    .frame   (poul16FrameCount[3:0]),
    .pattern (patLat),
    .pixel   (pix)
  );

  always_comb begin
    fvalD   = (state == P1) || (state == LINE) ||
              (state == HBLANK) || (state == P2);
    lvalD   = (state == LINE);
    dataD   = lvalD ? pix : '0;
    strobeD = fvalD && snapFrame;
  end

  // Outputs lag the state by one edge; the frame count steps on the FVAL fall.
  always_ff @(posedge piul1Clock or negedge piul1Reset_n) begin
    if (!piul1Reset_n) begin
      poul1FrameValid     <= 1'b0;
      poul1LineValid      <= 1'b0;
      poul12PixelData     <= '0;
      poul1SnapshotStrobe <= 1'b0;
      poul16FrameCount    <= '0;
    end else begin
      poul1FrameValid     <= fvalD;
      poul1LineValid      <= lvalD;
      poul12PixelData     <= dataD;
      poul1SnapshotStrobe <= strobeD;
      if (poul1FrameValid && !fvalD)
        poul16FrameCount <= poul16FrameCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_trdb_d5m_sensor_emulator.sv
// Directed self-checking bench for the TRDB-D5M sensor emulator.
// Small geometry: 8 cols, 4 rows, hblank 2, P1 3, P2 2, vblank 5.
module tb_trdb_d5m_sensor_emulator;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic [1:0]  pattern;
  logic        mode;
  logic        trig;
  logic        fval;
  logic        lval;
  logic [11:0] data;
  logic        strobe;
  logic [15:0] fcnt;

  int total = 0;
  int bad   = 0;

  trdb_d5m_sensor_emulator #(
    .ACTIVE_COLS (8),
    .ACTIVE_ROWS (4),
    .HBLANK_CC   (2),
    .P1_CC       (3),
    .P2_CC       (2),
    .VBLANK_CC   (5)
  ) dut (
    .piul1Clock           (clk),
    .piul1Reset_n         (rstN),
    .piul1Enable          (enable),
    .piul2Pattern         (pattern),
    .piul1SnapshotMode    (mode),
    .piul1SnapshotTrigger (trig),
    .poul1FrameValid      (fval),
    .poul1LineValid       (lval),
    .poul12PixelData      (data),
    .poul1SnapshotStrobe  (strobe),
    .poul16FrameCount     (fcnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int expPix(int pat, int c, int r, int f);
    case (pat)
      0:       return c;
      1:       return r;
      2:       return (((c >> 3) ^ (r >> 3)) & 1) ? 4095 : 0;
      default: return ((f & 15) << 8) | (c & 255);
    endcase
  endfunction

  // Entered on the first FVAL-high sample; leaves 48 cycles later.
  task automatic runFrame(input int f, input int pat, input int nextPat,
                          input bit snap, input int trigK, input bit dropEn);
    for (int k = 0; k < 48; k++) begin
      bit eF, eL;
      int c, r, eD;
      if (k == 20) pattern = 2'(nextPat);
      if (dropEn && k == 25) enable = 1'b0;
      if (k == trigK) trig = 1'b1;
      if (k == trigK + 2) trig = 1'b0;
      eF = (k < 43);
      c  = (k - 3) % 10;
      r  = (k - 3) / 10;
      eL = (k >= 3) && (k < 41) && (c < 8);
      eD = eL ? expPix(pat, c, r, f) : 0;
      check("fval", int'(fval), int'(eF));
      check("lval", int'(lval), int'(eL));
      check("data", int'(data), eD);
      check("fcnt", int'(fcnt), f + ((k >= 43) ? 1 : 0));
      check("strb", int'(strobe), int'(snap && eF));
      tick();
    end
  endtask

  task automatic idleCheck(input int n);
    int hi = 0;
    int st = 0;
    for (int i = 0; i < n; i++) begin
      hi += int'(fval);
      st += int'(strobe);
      tick();
    end
    check("idleFval", hi, 0);
    check("idleStrb", st, 0);
  endtask

  initial begin
    rstN    = 1'b0;
    enable  = 1'b0;
    pattern = 2'd0;
    mode    = 1'b0;
    trig    = 1'b0;
    repeat (3) tick();
    check("rstFval", int'(fval), 0);
    check("rstLval", int'(lval), 0);
    check("rstData", int'(data), 0);
    check("rstCnt",  int'(fcnt), 0);
    check("rstStrb", int'(strobe), 0);

    rstN   = 1'b1;
    enable = 1'b1;
    tick();
    check("lat0", int'(fval), 0);
    tick();
    check("lat1", int'(fval), 1);
    runFrame(0, 0, 3, 1'b0, -1, 1'b0);
    runFrame(1, 3, 3, 1'b0, -1, 1'b0);
    runFrame(2, 3, 3, 1'b0, -1, 1'b0);
    runFrame(3, 3, 3, 1'b0, -1, 1'b1);
    idleCheck(20);
    check("cntAfterDrop", int'(fcnt), 4);

    enable = 1'b1;
    tick();
    check("re0", int'(fval), 0);
    tick();
    check("re1", int'(fval), 1);
    repeat (5) tick();
    check("midLval", int'(lval), 1);
    check("midData", int'(data), 12'h402);
    #2 rstN = 1'b0;
    #1;
    check("arFval", int'(fval), 0);
    check("arLval", int'(lval), 0);
    check("arData", int'(data), 0);
    check("arCnt",  int'(fcnt), 0);
    @(negedge clk);
    rstN = 1'b1;
    tick();
    check("rel0", int'(fval), 0);
    tick();
    check("rel1", int'(fval), 1);
    runFrame(0, 3, 3, 1'b0, -1, 1'b1);
    idleCheck(10);

`ifdef TRDB_D5M_EMU_SNAPSHOT_EN
    mode = 1'b1;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    idleCheck(5);
    enable = 1'b1;
    tick();
    check("snap0", int'(fval), 0);
    tick();
    check("snap1", int'(fval), 1);
    runFrame(1, 3, 3, 1'b1, 45, 1'b0);
    runFrame(2, 3, 3, 1'b1, -1, 1'b0);
    idleCheck(30);
    check("snapCnt", int'(fcnt), 3);
`else
    mode   = 1'b1;
    trig   = 1'b1;
    enable = 1'b1;
    tick();
    trig = 1'b0;
    check("fr0", int'(fval), 0);
    tick();
    check("fr1", int'(fval), 1);
    runFrame(1, 3, 3, 1'b0, 10, 1'b0);
    runFrame(2, 3, 3, 1'b0, 45, 1'b1);
    idleCheck(20);
    check("frCnt", int'(fcnt), 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trdb_d5m_sensor_emulator.md
# trdb_d5m_sensor_emulator

Synthesizable stand-in for the TRDB-D5M image sensor: generates the sensor's parallel pixel stream (frame-valid, line-valid, 12-bit Bayer data, snapshot strobe) from programmable test patterns. It drives the same signals the sensor driver consumes, so the capture path and frame-transfer bus can be exercised on the board and in simulation without the camera fitted. It sits in the sensor clock domain and is selected in place of the pad inputs of the sensor interface.

## Interface
- ACTIVE_COLS, 640: pixels per line (LVAL high cycles), ≥2
- ACTIVE_ROWS, 480: lines per frame, ≥2
- HBLANK_CC, 16: LVAL-low cycles between lines, ≥1
- P1_CC, 8: FVAL-high/LVAL-low cycles before first line, ≥1
- P2_CC, 8: FVAL-high/LVAL-low cycles after last line, ≥1
- VBLANK_CC, 64: FVAL-low cycles between frames, ≥1
- piul1Clock  in  1  pixel clock; all logic on rising edge
- piul1Reset_n  in  1  reset, asynchronous, active-low
- piul1Enable  in  1  run frames while high
- piul2Pattern  in  2  pattern select, sampled at frame start
- piul1SnapshotMode  in  1  1 = one frame per trigger
- piul1SnapshotTrigger  in  1  rising edge requests a snapshot frame
- poul1FrameValid  out  1  FVAL
- poul1LineValid  out  1  LVAL
- poul12PixelData  out  12  pixel data, 0 when LVAL low
- poul1SnapshotStrobe  out  1  high for the whole FVAL of a snapshot frame
- poul16FrameCount  out  16  completed frames, wraps

## Operation
- States: IDLE, P1, LINE, HBLANK, P2, VBLANK.
- IDLE: all video outputs 0. Leave to P1 when (free-run: piul1Enable=1 and piul1SnapshotMode=0) or (snapshot: pending trigger and piul1Enable=1).
- P1: FVAL=1 for P1_CC cycles → LINE.
- LINE: LVAL=1 for ACTIVE_COLS cycles, column counter 0..ACTIVE_COLS-1; after last column → HBLANK if row<ACTIVE_ROWS-1, else P2.
- HBLANK: FVAL=1, LVAL=0 for HBLANK_CC cycles, row++ → LINE.
- P2: FVAL=1 for P2_CC cycles → VBLANK; frame counter increments on the FVAL fall.
- VBLANK: FVAL=0 for VBLANK_CC cycles → P1 if start condition true, else IDLE.
- Dropping piul1Enable mid-frame: current frame completes, including VBLANK, then IDLE. No truncated frames.
- Patterns (col, row are 0-based, truncated to 12 bits): 0 = col; 1 = row; 2 = checkerboard, 12'hFFF when (col[3]^row[3]) else 0; 3 = {frame[3:0], col[7:0]}. Pattern and mode are latched at P1 entry and held for the frame.
- Reset mid-frame: asynchronously forces IDLE. All outputs, counters and pending trigger go to 0.

## Timing
- All outputs registered. Reset value of every output is 0.
- Start latency: enable (or trigger edge) sampled high in IDLE at edge N → FVAL=1 after edge N+1.
- LVAL and data change on the same edge. The first pixel of each line is valid on the cycle LVAL rises.
- Frame period = P1_CC + ACTIVE_ROWS·ACTIVE_COLS + (ACTIVE_ROWS-1)·HBLANK_CC + P2_CC + VBLANK_CC. Back-to-back frames have no extra idle cycle.
- Counters are sized by $clog2 of their parameter. No overflow at maximum parameter values.

## Configuration
- TRDB_D5M_EMU_SNAPSHOT_EN defined: snapshot mode is active.
  - Trigger edge detector: one register. A rising edge seen in any state sets a pending flag; a second edge while pending is dropped.
  - The pending flag is cleared at P1 entry.
  - The strobe mirrors FVAL for snapshot frames only.
- Not defined: piul1SnapshotMode and piul1SnapshotTrigger are ignored, poul1SnapshotStrobe is tied 0, and only free-run operates.

## Structure
- Shared package tPTRDB_D5M_Emu holds:
  - state enum (IDLE…VBLANK)
  - pattern enum (COL_RAMP, ROW_RAMP, CHECKER, FRAME_TAG)
  - the 12-bit pixel width constant
- Sub-module tMD5MPatternGen: combinational pattern select from col, row, frame and latched pattern. Registered in the top FSM stage.

## Test plan
- Use small params for all scenarios: COLS=8, ROWS=4, HBLANK=2, P1=3, P2=2, VBLANK=5.
- Free-run, pattern 0 → FVAL high 43 cycles, period 48; 4 LVAL bursts of 8 with data 0..7; frame count 1,2,3 at successive FVAL falls.
- Pattern 3, second frame → data {4'h1, col} = 12'h100..12'h107 on every line.
- Enable dropped during row 2 → frame finishes all 4 lines plus P2 and VBLANK, then IDLE; FVAL stays 0.
- Reset asserted during LINE → FVAL, LVAL, data, frame count read 0 immediately; after release with enable=1, FVAL rises 2 edges later.
- Snapshot (macro on), mode=1, two trigger edges 3 cycles apart while IDLE → exactly one frame, strobe equal to FVAL; a trigger during VBLANK → one further frame follows directly.
- Macro off, mode=1 with triggers → free-run frames, strobe constantly 0.
